// File: rtl/denise_sprite_channel.sv
// denise_sprite_channel: one sprite channel -- POS/CTL/DATA/DATB registers, arm on DATA, 16-pixel serialiser fired at HSTART
module denise_sprite_channel #(
  parameter logic [8:0] BASE = 9'h140
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk7_en,
  input  logic [7:0]  reg_address_in,
  input  logic [15:0] data_in,
  input  logic [8:0]  hpos,
  output logic [1:0]  sprdata,
  output logic        nsprite,
  output logic        attach,
  output logic        active
);
  localparam logic [8:0] CTL_A  = BASE + 9'd2;
  localparam logic [8:0] DATA_A = BASE + 9'd4;
  localparam logic [8:0] DATB_A = BASE + 9'd6;
  logic [8:0]  hstart_q;
  logic [15:0] data_q, datb_q, sha_q, shb_q;
  logic [3:0]  cnt_q;
  logic        attach_q, armed_q, active_q;
  logic        pos_wr, ctl_wr, data_wr, datb_wr, match;
  assign pos_wr  = clk7_en && reg_address_in == BASE[8:1];
  assign ctl_wr  = clk7_en && reg_address_in == CTL_A[8:1];
  assign data_wr = clk7_en && reg_address_in == DATA_A[8:1];
  assign datb_wr = clk7_en && reg_address_in == DATB_A[8:1];
  // A CTL write in the match cycle disarms before the load can happen
  assign match   = clk7_en && armed_q && hpos == hstart_q && !ctl_wr;
  always_ff @(posedge clk) begin
    if (reset) begin
      hstart_q <= '0;
      attach_q <= 1'b0;
      data_q   <= '0;
      datb_q   <= '0;
      sha_q    <= '0;
      shb_q    <= '0;
      armed_q  <= 1'b0;
      cnt_q    <= '0;
      active_q <= 1'b0;
    end else if (clk7_en) begin
      if (pos_wr) hstart_q[8:1] <= data_in[7:0];
      if (ctl_wr) begin
        hstart_q[0] <= data_in[0];
        attach_q    <= data_in[7];
        armed_q     <= 1'b0;
      end
      if (data_wr) begin
        data_q  <= data_in;
        armed_q <= 1'b1;
      end
      if (datb_wr) datb_q <= data_in;
      if (match) begin
        sha_q    <= data_q;
        shb_q    <= datb_q;
        cnt_q    <= 4'd15;
        active_q <= 1'b1;
      end else if (active_q) begin
        sha_q    <= {sha_q[14:0], 1'b0};
        shb_q    <= {shb_q[14:0], 1'b0};
        cnt_q    <= cnt_q - 4'd1;
        active_q <= cnt_q != 4'd0;
      end
    end
  end
  assign sprdata = {shb_q[15], sha_q[15]};
  assign nsprite = |sprdata;
  assign attach  = attach_q;
  assign active  = active_q;
endmodule

// File: doc/denise_sprite_channel.md
Name: denise_sprite_channel

Overview:
- One hardware sprite channel of Denise: holds the SPRxPOS/SPRxCTL/SPRxDATA/SPRxDATB registers, arms on a data write, and fires when the beam reaches HSTART.
- Serialises 16 two-bit pixels per line.
- Eight instances (BASE stepped by 8 bytes) feed the per-sprite pixel codes and the nsprite[7:0] video-status vector consumed directly by the sprite priority stage.

Parameters:
BASE, 9'h140, byte address of this channel's SPRxPOS register; CTL = BASE+2, DATA = BASE+4, DATB = BASE+6

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
clk7_en  in  1  7 MHz pixel enable; all state changes qualified by it (reset excepted)
reg_address_in  in  8  register bus word address [8:1]
data_in  in  16  register bus write data
hpos  in  9  current horizontal beam position, lores resolution
sprdata  out  2  current pixel code {DATB bit, DATA bit}
nsprite  out  1  sprite video status: 1 when sprdata != 0
attach  out  1  SPRxCTL bit 7 (attach request to odd/even pairing)
active  out  1  high while a 16-pixel burst is being shifted out

Behaviour:
- All sequential logic on posedge clk; reset (synchronous, active-high) has priority over everything and is not gated by clk7_en.
- Reset values: hstart=0, attach=0, data/datb=0, shifter A/B=0, armed=0, pixel counter=0, active=0; hence sprdata=2'b00 and nsprite=0.
- Register decode (write when clk7_en and reg_address_in == address[8:1]):
  - POS: hstart[8:1] <= data_in[7:0]; hstart[0] unchanged.
  - CTL: hstart[0] <= data_in[0]; attach <= data_in[7]; armed <= 0.
  - DATA: data <= data_in; armed <= 1.
  - DATB: datb <= data_in; armed unchanged.
- Match condition: clk7_en && armed (registered value, before any same-cycle write) && hpos == hstart && no CTL write this cycle.
- On match: shiftA <= data; shiftB <= datb; counter <= 15; active <= 1. The register contents used are those held before the cycle; a DATA/DATB write in the match cycle affects the next match only.
- Otherwise, on clk7_en with active=1: shiftA/B shift left by 1 with zero fill; counter decrements; when counter==0, active <= 0 on that same edge.
- Load and shift in the same cycle: load wins, and the burst restarts from pixel 15.
- sprdata = {shiftB[15], shiftA[15]}, combinational from the shifter MSBs.
  - First pixel is visible the cycle after the match edge.
  - Exactly 16 clk7_en pixels per burst; after that sprdata=0 because the shifter is drained.
- nsprite = |sprdata. attach is a registered copy of CTL bit 7.
- armed is not cleared by firing; the same data re-fires on every line at hstart until a CTL write.
- hpos values above 9'h1C7 never match in practice; no wrap handling is required. Comparison is an exact 9-bit equality.
- Reset mid-burst: all outputs are 0 on the next cycle and armed=0.
- No output is affected on cycles with clk7_en=0; state holds.

Test Plan:
- Reset then idle 100 cycles with hpos sweeping 0..1C7 -> sprdata=0, nsprite=0, active=0 throughout.
- Write POS=16'h0040, CTL=16'h0001, DATB=16'h0000, DATA=16'hF00F; sweep hpos -> match at hpos=9'h081. The 16 pixels following are 01 x4, 00 x8, 01 x4. nsprite follows. active is high for 16 pixels.
- Same as above with DATB=16'hFFFF and CTL=16'h0081 -> pixels 11,11,11,11 then 10 x8 then 11 x4. attach=1.
- Write CTL while armed, before hstart -> no burst on that line or later lines until DATA is written again.
- Write CTL in the exact match cycle -> no load. Write DATA=16'h8000 in the match cycle of an armed channel holding 16'hFFFF -> burst shows the old value FFFF; the next line shows 8000.
- Assert reset at pixel 7 of a burst -> sprdata=0 and active=0 next cycle. Subsequent lines produce no burst until the channel is re-armed.
